aplic_msi_forwarder: RTL and testbench
======================================

Name: aplic_msi_forwarder

Overview:
- Downstream consumer of the APLIC selection primitives (first-set mask, mask-after-index, one-hot index, one-hot select).
- Scans the pending-and-enabled interrupt sources of one domain in round-robin order and forms an MSI write (address, data) for the chosen source.
- Presents the write on a valid/ready handshake and, on acceptance, issues a one-cycle clear-pending request back to the source-state logic.
- Sits between the per-source pending/enable/target registers and the bus-master MSI write port.

Parameters:
numSources, 32, width of source vectors; index 0 is reserved and never selected
hartIxW, 4, width of target hart index
eiidW, 11, width of external interrupt identity
addrW, 56, MSI address width; base PPN width is addrW-12

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
domainIE  in  1  domain interrupt enable
pending  in  numSources  per-source pending bits
enabled  in  numSources  per-source enable bits
targetHart  in  hartIxW x numSources  per-source target hart index
targetEIID  in  eiidW x numSources  per-source target EIID
basePPN  in  addrW-12  MSI address base page number
msiValid  out  1  MSI write request valid
msiReady  in  1  MSI write accepted when valid&&ready
msiAddr  out  addrW  (basePPN + hart)<<12, truncated to addrW
msiData  out  32  EIID zero-extended
clrPendValid  out  1  one-cycle pulse: clear pending of clrPendIx
clrPendIx  out  $clog2(numSources)  source to clear
busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate):
  - state=IDLE, msiValid=0, clrPendValid=0, lastIx=0.
  - msiAddr, msiData, clrPendIx and the selected-source register = 0.
- Candidate vector: cand = pending & enabled & ~1 (bit 0 forced to 0), gated by domainIE.
- Round-robin pick (combinational):
  - hi = cand & maskAfter(lastIx).
  - pick = first-set(hi) if |hi, else first-set(cand).
  - selIx = index(pick); hart and EIID via one-hot select.
- FSM states: IDLE, SEND, DRAIN.
- IDLE, when |cand in cycle t:
  - Register selIx, msiAddr and msiData.
  - msiValid=1 from t+1; go to SEND.
  - No candidate: remain in IDLE.
- SEND:
  - msiValid, msiAddr, msiData and selIx stay stable until msiValid&&msiReady.
  - On the handshake cycle h: at h+1, msiValid=0, clrPendValid=1, clrPendIx=selIx, lastIx<=selIx, go to DRAIN.
- DRAIN: clrPendValid=0 and the state returns to IDLE next cycle. This gives the source logic one cycle to drop pending before a rescan.
- Minimum spacing between consecutive msiValid rising edges is 3 cycles when msiReady is tied high.
- Once in SEND, the request is committed:
  - Deassertion of pending, enabled or domainIE does not withdraw msiValid.
  - The MSI completes and the clear pulse is still issued.
- Target tables and basePPN are sampled only in IDLE; later changes do not alter an in-flight request.
- Wrap: when lastIx = numSources-1, hi is empty and the lowest-indexed candidate wins.
- Single candidate equal to lastIx: it is re-selected via the wrap path.
- Address arithmetic:
  - basePPN + hart is done modulo 2^(addrW-12), with no carry-out.
  - hart is zero-extended.
- Reset mid-SEND: msiValid drops at once and no clear pulse is issued.
- msiValid must not depend combinationally on msiReady.

Decomposition:
- Package aplic_msi_pkg holds:
  - the FSM state enum (IDLE, SEND, DRAIN);
  - the constant MSI_PAGE_SHIFT = 12;
  - the data width constant 32.
- Sub-module aplic_rr_pick:
  - Purely combinational round-robin picker, built from the existing primitives (mask-after-index, first-set, one-hot index, one-hot select).
  - Outputs a valid flag, selIx, hart and EIID.
- The forwarder holds only registers and the FSM.

Test Plan:
- Reset mid-SEND with msiReady=0 -> msiValid=0 immediately, busy=0, no clrPendValid; after release with pending unchanged, the same source is re-sent at t+1.
- domainIE=1, pending=enabled=0x0000_0020, targetHart[5]=3, targetEIID[5]=0x2A, basePPN=0x100, ready=1 -> msiValid at t+1, msiAddr=0x103000, msiData=0x2A; clrPendValid pulse with clrPendIx=5.
- pending=enabled=0x0000_0115 (bits 0,2,4,8), pending held after each clear -> sends in order 2, 4, 8, 2 (bit 0 never chosen).
- lastIx=31, candidates {3,31} -> selects 3 (wrap); then selects 31.
- msiReady=0 for 5 cycles while pending drops and domainIE=0 -> msiValid, addr and data held stable; on ready=1, exactly one clear pulse is issued.
- basePPN=all ones (44 bits), hart=1 -> msiAddr=0 (wrap modulo 2^44, shifted by 12).

Source files
------------

// File: rtl/aplic_msi_forwarder_pkg.sv
// aplic_msi_pkg: shared FSM state type and MSI framing constants for the forwarder
package aplic_msi_pkg;
  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_e;
  localparam int MSI_PAGE_SHIFT = 12;
  localparam int MSI_DATA_W = 32;
endpackage

// File: rtl/aplic_msi_forwarder_if.sv
// aplic_msi_forwarder_if: MSI write channel
//   valid/addr/data driven by the master, ready driven by the slave;
//   a write is accepted on a cycle with valid && ready.
interface aplic_msi_forwarder_if
  import aplic_msi_pkg::*;
#(
  parameter int ADDR_W = 56
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_W-1:0]     addr;
  logic [MSI_DATA_W-1:0] data;
  modport master(output valid, addr, data, input ready);
  modport slave(input valid, addr, data, output ready);
endinterface

// File: rtl/aplic_msi_forwarder_rr_pick.sv
// aplic_rr_pick: combinational round-robin choice among pending&enabled sources
//   domain_ie_i, pending_i, enabled_i : candidate qualification (source 0 never chosen)
//   last_ix_i                         : most recently served source
//   target_hart_i, target_eiid_i      : per-source routing tables
//   valid_o, sel_ix_o, hart_o, eiid_o : chosen source and its routing
module aplic_rr_pick #(
  parameter int NUM_SOURCES = 32,
  parameter int HART_W      = 4,
  parameter int EIID_W      = 11,
  localparam int IX_W       = $clog2(NUM_SOURCES)
) (
  input  logic                                domain_ie_i,
  input  logic [NUM_SOURCES-1:0]              pending_i,
  input  logic [NUM_SOURCES-1:0]              enabled_i,
  input  logic [IX_W-1:0]                     last_ix_i,
  input  logic [NUM_SOURCES-1:0][HART_W-1:0]  target_hart_i,
  input  logic [NUM_SOURCES-1:0][EIID_W-1:0]  target_eiid_i,
  output logic                                valid_o,
  output logic [IX_W-1:0]                     sel_ix_o,
  output logic [HART_W-1:0]                   hart_o,
  output logic [EIID_W-1:0]                   eiid_o
);
  localparam logic [NUM_SOURCES-1:0] ONE = NUM_SOURCES'(1);
  logic [NUM_SOURCES-1:0] cand, after, hi, src, pick;
  always_comb begin
    cand = pending_i & enabled_i & ~ONE & {NUM_SOURCES{domain_ie_i}};
    for (int i = 0; i < NUM_SOURCES; i++) after[i] = i > int'(last_ix_i);
    hi = cand & after;
    // Nothing above last_ix wraps back to the lowest candidate.
    src = |hi ? hi : cand;
    pick = src & (~src + ONE);
    valid_o = |cand;
    sel_ix_o = '0;
    hart_o = '0;
    eiid_o = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      sel_ix_o |= pick[i] ? IX_W'(i) : '0;
      hart_o |= pick[i] ? target_hart_i[i] : '0;
      eiid_o |= pick[i] ? target_eiid_i[i] : '0;
    end
  end
endmodule

// File: rtl/aplic_msi_forwarder.sv
// aplic_msi_forwarder: turns pending&enabled sources of one domain into MSI writes
//   clk, rst                      : clock, asynchronous active-high reset
//   domain_ie_i                   : domain interrupt enable
//   pending_i, enabled_i          : per-source pending / enable bits
//   target_hart_i, target_eiid_i  : per-source routing tables
//   base_ppn_i                    : MSI address base page number
//   msi                           : MSI write channel (master side)
//   clr_pend_valid_o, clr_pend_ix_o : one-cycle clear-pending request
//   busy_o                        : a request is in flight or draining
module aplic_msi_forwarder
  import aplic_msi_pkg::*;
#(
  parameter int NUM_SOURCES = 32,
  parameter int HART_W      = 4,
  parameter int EIID_W      = 11,
  parameter int ADDR_W      = 56,
  localparam int IX_W       = $clog2(NUM_SOURCES),
  localparam int PPN_W      = ADDR_W - MSI_PAGE_SHIFT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                domain_ie_i,
  input  logic [NUM_SOURCES-1:0]              pending_i,
  input  logic [NUM_SOURCES-1:0]              enabled_i,
  input  logic [NUM_SOURCES-1:0][HART_W-1:0]  target_hart_i,
  input  logic [NUM_SOURCES-1:0][EIID_W-1:0]  target_eiid_i,
  input  logic [PPN_W-1:0]                    base_ppn_i,
  aplic_msi_forwarder_if.master               msi,
  output logic                                clr_pend_valid_o,
  output logic [IX_W-1:0]                     clr_pend_ix_o,
  output logic                                busy_o
);
  state_e                state_q, state_d;
  logic [IX_W-1:0]       sel_ix_q, sel_ix_d, last_ix_q, last_ix_d, clr_ix_q, clr_ix_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [MSI_DATA_W-1:0] data_q, data_d;
  logic                  valid_q, valid_d, clr_valid_q, clr_valid_d;
  logic                  pick_valid;
  logic [IX_W-1:0]       pick_ix;
  logic [HART_W-1:0]     pick_hart;
  logic [EIID_W-1:0]     pick_eiid;
  logic [PPN_W-1:0]      ppn;
  aplic_rr_pick #(.NUM_SOURCES(NUM_SOURCES), .HART_W(HART_W), .EIID_W(EIID_W)) u_pick (
    .domain_ie_i  (domain_ie_i),
    .pending_i    (pending_i),
    .enabled_i    (enabled_i),
    .last_ix_i    (last_ix_q),
    .target_hart_i(target_hart_i),
    .target_eiid_i(target_eiid_i),
    .valid_o      (pick_valid),
    .sel_ix_o     (pick_ix),
    .hart_o       (pick_hart),
    .eiid_o       (pick_eiid)
  );
  // Page number sum wraps within PPN_W; the carry-out is discarded.
  assign ppn = base_ppn_i + PPN_W'(pick_hart);
  always_comb begin
    state_d = state_q;
    sel_ix_d = sel_ix_q;
    last_ix_d = last_ix_q;
    clr_ix_d = clr_ix_q;
    addr_d = addr_q;
    data_d = data_q;
    valid_d = valid_q;
    clr_valid_d = 1'b0;
    case (state_q)
      IDLE: if (pick_valid) begin
        sel_ix_d = pick_ix;
        addr_d = {ppn, {MSI_PAGE_SHIFT{1'b0}}};
        data_d = MSI_DATA_W'(pick_eiid);
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: if (msi.ready) begin
        valid_d = 1'b0;
        clr_valid_d = 1'b1;
        clr_ix_d = sel_ix_q;
        last_ix_d = sel_ix_q;
        state_d = DRAIN;
      end
      // One idle cycle lets the source logic drop pending before the next scan.
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_ix_q <= '0;
      last_ix_q <= '0;
      clr_ix_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      clr_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_ix_q <= sel_ix_d;
      last_ix_q <= last_ix_d;
      clr_ix_q <= clr_ix_d;
      addr_q <= addr_d;
      data_q <= data_d;
      valid_q <= valid_d;
      clr_valid_q <= clr_valid_d;
    end
  end
  assign msi.valid = valid_q;
  assign msi.addr = addr_q;
  assign msi.data = data_q;
  assign clr_pend_valid_o = clr_valid_q;
  assign clr_pend_ix_o = clr_ix_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_aplic_msi_forwarder.sv
// tb_aplic_msi_forwarder: scenario tasks against a scan-based round-robin reference
module tb_aplic_msi_forwarder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ie = 1'b0;
  logic [31:0] pend = '0, en = '0;
  logic [31:0][3:0] hart = '0;
  logic [31:0][10:0] eiid = '0;
  logic [43:0] base = '0;
  logic clr_v, busy;
  logic [4:0] clr_ix;
  logic [55:0] obs_addr;
  logic [31:0] obs_data;
  int checks = 0, fails = 0, last_m = 0;

  always #5 clk = ~clk;

  aplic_msi_forwarder_if #(.ADDR_W(56)) msi ();

  aplic_msi_forwarder #(.NUM_SOURCES(32), .HART_W(4), .EIID_W(11), .ADDR_W(56)) dut (
    .clk(clk), .rst(rst), .domain_ie_i(ie), .pending_i(pend), .enabled_i(en),
    .target_hart_i(hart), .target_eiid_i(eiid), .base_ppn_i(base), .msi(msi),
    .clr_pend_valid_o(clr_v), .clr_pend_ix_o(clr_ix), .busy_o(busy)
  );

  initial begin
    msi.ready = 1'b0;
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  function automatic int model_pick();
    logic [31:0] c = pend & en & {32{ie}};
    for (int k = 1; k <= 32; k++) begin
      int i = (last_m + k) % 32;
      if (i != 0 && c[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [55:0] model_addr(int i);
    logic [63:0] s = (64'(base) + 64'(hart[i])) % (64'd1 << 44);
    return 56'(s * 64'd4096);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_m = 0;
  endtask

  task automatic rand_tables();
    for (int k = 0; k < 32; k++) begin
      hart[k] = 4'($urandom);
      eiid[k] = 11'($urandom);
    end
    base = {12'($urandom), 32'($urandom)};
  endtask

  // DUT idle with inputs set; serves one MSI, stalling ready for 'stall' cycles.
  task automatic run_one(input bit clr, input int stall, input bit perturb, output int got);
    int e;
    logic [55:0] ea;
    logic [31:0] ed;
    e = model_pick();
    got = -1;
    ea = e > 0 ? model_addr(e) : '0;
    ed = e > 0 ? 32'(eiid[e]) : '0;
    msi.ready = stall == 0;
    tick();
    obs_addr = msi.addr;
    obs_data = msi.data;
    checks++;
    if (msi.valid !== 1'b1 || busy !== 1'b1 || e < 0) begin
      fails++;
      $display("FAIL valid_rise: valid=%b busy=%b required 1 1 (model src %0d)", msi.valid, busy, e);
      msi.ready = 1'b1;
      return;
    end
    checks++;
    if (msi.addr !== ea || msi.data !== ed) begin
      fails++;
      $display("FAIL msi_payload: addr=%h data=%h required addr=%h data=%h", msi.addr, msi.data, ea, ed);
    end
    for (int s = 0; s < stall; s++) begin
      if (perturb && s == 0) begin
        pend = '0;
        ie = 1'b0;
        rand_tables();
      end
      tick();
      checks++;
      if (msi.valid !== 1'b1 || msi.addr !== ea || msi.data !== ed || clr_v !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold: valid=%b addr=%h data=%h clr=%b required 1 %h %h 0", msi.valid, msi.addr, msi.data, clr_v, ea, ed);
      end
    end
    msi.ready = 1'b1;
    tick();
    got = int'(clr_ix);
    checks++;
    if (msi.valid !== 1'b0 || clr_v !== 1'b1 || clr_ix !== 5'(e)) begin
      fails++;
      $display("FAIL clear_pulse: valid=%b clr=%b ix=%0d required 0 1 %0d", msi.valid, clr_v, clr_ix, e);
    end
    last_m = e;
    if (clr) pend[e] = 1'b0;
    tick();
    checks++;
    if (clr_v !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL drain_end: clr=%b busy=%b required 0 0", clr_v, busy);
    end
  endtask

  task automatic test_reset();
    ie = 1'b1;
    pend = 32'h10;
    en = 32'h10;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (msi.valid !== 1'b0 || busy !== 1'b0 || clr_v !== 1'b0 || msi.addr !== '0 || msi.data !== '0 || clr_ix !== '0) begin
      fails++;
      $display("FAIL reset_state: valid=%b busy=%b clr=%b addr=%h data=%h ix=%0d required all zero", msi.valid, busy, clr_v, msi.addr, msi.data, clr_ix);
    end
    pend = '0;
    en = '0;
    rst = 1'b0;
    last_m = 0;
  endtask

  task automatic test_basic();
    int g;
    do_reset();
    ie = 1'b1;
    pend = 32'h20;
    en = 32'h20;
    hart[5] = 4'd3;
    eiid[5] = 11'h2A;
    base = 44'h100;
    run_one(1'b1, 0, 1'b0, g);
    checks++;
    if (obs_addr !== 56'h103000 || obs_data !== 32'h2A || g !== 5) begin
      fails++;
      $display("FAIL basic_msi: addr=%h data=%h ix=%0d required 103000 2a 5", obs_addr, obs_data, g);
    end
    pend = 32'h20;
    ie = 1'b0;
    repeat (3) tick();
    checks++;
    if (msi.valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL domain_off_idle: valid=%b busy=%b required 0 0", msi.valid, busy);
    end
    pend = '0;
  endtask

  task automatic test_order();
    int g;
    int exp_ix[4] = '{2, 4, 8, 2};
    do_reset();
    rand_tables();
    ie = 1'b1;
    pend = 32'h115;
    en = 32'h115;
    for (int j = 0; j < 4; j++) begin
      run_one(1'b0, 0, 1'b0, g);
      checks++;
      if (g !== exp_ix[j]) begin
        fails++;
        $display("FAIL rr_order[%0d]: ix=%0d required %0d", j, g, exp_ix[j]);
      end
    end
    pend = '0;
    tick();
  endtask

  task automatic test_wrap();
    int g;
    int exp_ix[4] = '{31, 3, 31, 31};
    logic [31:0] pat[4] = '{32'h8000_0000, 32'h8000_0008, 32'h8000_0008, 32'h8000_0000};
    do_reset();
    rand_tables();
    ie = 1'b1;
    for (int j = 0; j < 4; j++) begin
      pend = pat[j];
      en = pat[j];
      run_one(1'b0, 0, 1'b0, g);
      checks++;
      if (g !== exp_ix[j]) begin
        fails++;
        $display("FAIL wrap_pick[%0d]: ix=%0d required %0d", j, g, exp_ix[j]);
      end
    end
    pend = '0;
    tick();
  endtask

  task automatic test_hold();
    int g, pulses, vals;
    do_reset();
    rand_tables();
    ie = 1'b1;
    pend = 32'h200;
    en = 32'h200;
    run_one(1'b1, 5, 1'b1, g);
    pulses = 0;
    vals = 0;
    repeat (4) begin
      tick();
      pulses += int'(clr_v);
      vals += int'(msi.valid);
    end
    checks++;
    if (g !== 9 || pulses !== 0 || vals !== 0) begin
      fails++;
      $display("FAIL hold_commit: ix=%0d extra_clr=%0d extra_valid=%0d required 9 0 0", g, pulses, vals);
    end
  endtask

  task automatic test_addr_wrap();
    int g;
    do_reset();
    ie = 1'b1;
    pend = 32'h40;
    en = 32'h40;
    hart[6] = 4'd1;
    base = '1;
    run_one(1'b1, 0, 1'b0, g);
    checks++;
    if (obs_addr !== 56'h0) begin
      fails++;
      $display("FAIL addr_wrap: addr=%h required 0", obs_addr);
    end
  endtask

  task automatic test_reset_mid_send();
    int g;
    do_reset();
    rand_tables();
    ie = 1'b1;
    pend = 32'h80;
    en = 32'h80;
    msi.ready = 1'b0;
    tick();
    checks++;
    if (msi.valid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_valid: valid=%b required 1", msi.valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (msi.valid !== 1'b0 || busy !== 1'b0 || clr_v !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: valid=%b busy=%b clr=%b required 0 0 0", msi.valid, busy, clr_v);
    end
    tick();
    checks++;
    if (clr_v !== 1'b0 || msi.valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_clear: clr=%b valid=%b required 0 0", clr_v, msi.valid);
    end
    @(negedge clk);
    rst = 1'b0;
    last_m = 0;
    run_one(1'b1, 0, 1'b0, g);
    checks++;
    if (g !== 7) begin
      fails++;
      $display("FAIL resend_after_reset: ix=%0d required 7", g);
    end
  endtask

  task automatic test_random();
    int g, k;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      rand_tables();
      ie = 1'b1;
      pend = $urandom;
      en = $urandom;
      k = $urandom_range(1, 31);
      pend[k] = 1'b1;
      en[k] = 1'b1;
      run_one(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, g);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_order();
    test_wrap();
    test_hold();
    test_addr_wrap();
    test_reset_mid_send();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
